// File: rtl/rps_pkg.sv
// Shared definitions for the stone-paper-scissors pipeline.
// The judge stage also imports this package for the result codes.
package rps_pkg;

  localparam logic [7:0] RES_TIE = 8'd0;
  localparam logic [7:0] RES_P1  = 8'd49;
  localparam logic [7:0] RES_P2  = 8'd50;
  localparam logic [7:0] RES_INV = 8'd63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/rps_match_scorer_if.sv
// Round-result handshake between the judge stage (master) and the scorer (slave).
interface rps_match_scorer_if;

  logic [7:0] result_in;
  logic       result_valid;
  logic       result_ready;

  modport master (output result_in, output result_valid, input result_ready);
  modport slave  (input result_in, input result_valid, output result_ready);

endinterface

// File: rtl/rps_result_decode.sv
// Maps a round-result code to one-hot {p1, p2, tie, invalid}.
// Any code outside the three meaningful values is treated as invalid.
module rps_result_decode
  import rps_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       p1_o,
  output logic       p2_o,
  output logic       tie_o,
  output logic       inv_o
);

  always_comb begin
    p1_o  = 1'b0;
    p2_o  = 1'b0;
    tie_o = 1'b0;
    inv_o = 1'b0;
    case (code_i)
      RES_P1:  p1_o  = 1'b1;
      RES_P2:  p2_o  = 1'b1;
      RES_TIE: tie_o = 1'b1;
      default: inv_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rps_match_scorer.sv
// First-to-WIN_TARGET match scorer with a round limit; declares the match winner.
// State table:  IDLE | waiting for start
//               PLAY | accepting round results
//               OVER | match decided, results ignored until start
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int SCORE_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  rps_match_scorer_if.slave    res_if,
  output logic [SCORE_W-1:0]   p1_score,
  output logic [SCORE_W-1:0]   p2_score,
  output logic [7:0]           round_cnt,
  output logic [7:0]           invalid_cnt,
  output logic                 match_over,
  output logic [1:0]           match_winner
);

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [7:0]         LIMIT  = 8'(MAX_ROUNDS);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [7:0]           rnd_q, rnd_d, inv_q, inv_d;
  logic [1:0]           win_q, win_d;
  logic                 dec_p1, dec_p2, dec_tie, dec_inv;

  rps_result_decode u_decode (
    .code_i (res_if.result_in),
    .p1_o   (dec_p1),
    .p2_o   (dec_p2),
    .tie_o  (dec_tie),
    .inv_o  (dec_inv)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      rnd_q   <= '0;
      inv_q   <= '0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      rnd_q   <= rnd_d;
      inv_q   <= inv_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    rnd_d   = rnd_q;
    inv_d   = inv_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (start) state_d = PLAY;
      PLAY: begin
        if (res_if.result_valid) begin
          if (dec_p1) p1_d = p1_q + 1'b1;
          if (dec_p2) p2_d = p2_q + 1'b1;
          if (dec_p1 || dec_p2 || dec_tie) rnd_d = rnd_q + 8'd1;
          if (dec_inv && inv_q != 8'hFF) inv_d = inv_q + 8'd1;
          // End check uses the post-increment values of this same accept.
          if (p1_d == TARGET) begin
            state_d = OVER;
            win_d   = WIN_P1;
          end else if (p2_d == TARGET) begin
            state_d = OVER;
            win_d   = WIN_P2;
          end else if (rnd_d == LIMIT) begin
            state_d = OVER;
            win_d   = (p1_d > p2_d) ? WIN_P1 : (p2_d > p1_d) ? WIN_P2 : WIN_NONE;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d = PLAY;
          p1_d    = '0;
          p2_d    = '0;
          rnd_d   = '0;
          inv_d   = '0;
          win_d   = WIN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_if.result_ready = (state_q == PLAY);
  assign match_over          = (state_q == OVER);
  assign p1_score            = p1_q;
  assign p2_score            = p2_q;
  assign round_cnt           = rnd_q;
  assign invalid_cnt         = inv_q;
  assign match_winner        = win_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed and randomized bench for rps_match_scorer against a behavioural match model.
module tb_rps_match_scorer;

  localparam int WT = 3;
  localparam int MR = 9;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] p1_score, p2_score;
  logic [7:0]    round_cnt, invalid_cnt;
  logic          match_over;
  logic [1:0]    match_winner;

  rps_match_scorer_if res_if ();

  rps_match_scorer #(.WIN_TARGET(WT), .MAX_ROUNDS(MR), .SCORE_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .res_if       (res_if),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .round_cnt    (round_cnt),
    .invalid_cnt  (invalid_cnt),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural match model: plain integers and two flags.
  int m_s1, m_s2, m_rounds, m_inv, m_win;
  bit m_playing, m_over;

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_rounds = 0; m_inv = 0; m_win = 0;
  endtask

  task automatic model_edge(input bit rn, input bit st, input bit v, input logic [7:0] code);
    if (!rn) begin
      model_clear();
      m_playing = 0;
      m_over = 0;
    end else if (m_over) begin
      if (st) begin
        model_clear();
        m_over = 0;
        m_playing = 1;
      end
    end else if (!m_playing) begin
      if (st) m_playing = 1;
    end else if (v) begin
      if (code == 8'd49) begin m_s1++; m_rounds++; end
      else if (code == 8'd50) begin m_s2++; m_rounds++; end
      else if (code == 8'd0) m_rounds++;
      else if (m_inv < 255) m_inv++;
      if (m_s1 == WT) begin m_over = 1; m_win = 1; end
      else if (m_s2 == WT) begin m_over = 1; m_win = 2; end
      else if (m_rounds == MR) begin
        m_over = 1;
        m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 0;
      end
      if (m_over) m_playing = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ready",   32'(res_if.result_ready), 32'(m_playing));
    chk("over",    32'(match_over),          32'(m_over));
    chk("p1",      32'(p1_score),            32'(m_s1));
    chk("p2",      32'(p2_score),            32'(m_s2));
    chk("rounds",  32'(round_cnt),           32'(m_rounds));
    chk("invalid", 32'(invalid_cnt),         32'(m_inv));
    if (m_over) chk("winner", 32'(match_winner), 32'(m_win));
  endtask

  task automatic step(input bit st, input bit v, input logic [7:0] code, input bit rn = 1'b1);
    rst_n = rn;
    start = st;
    res_if.result_valid = v;
    res_if.result_in = code;
    @(posedge clk);
    model_edge(rn, st, v, code);
    #1;
    check_model();
  endtask

  task automatic play(input logic [7:0] code);
    step(1'b0, 1'b1, code);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    res_if.result_valid = 1'b0;
    res_if.result_in = 8'd0;
    model_clear();
    m_playing = 0;
    m_over = 0;

    // Reset state
    step(1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("rst_winner", 32'(match_winner), 32'd0);

    // P1 takes the match 3-0; following valid 50 must be ignored
    step(1'b1, 1'b0, 8'd0);
    play(8'd49); play(8'd49); play(8'd49);
    chk("t1_winner", 32'(match_winner), 32'd1);
    chk("t1_over", 32'(match_over), 32'd1);
    play(8'd50);
    chk("t1_p2", 32'(p2_score), 32'd0);

    // P2 takes the match with a tie and an invalid in between
    step(1'b1, 1'b0, 8'd0);
    play(8'd50); play(8'd0); play(8'd50); play(8'd63); play(8'd50);
    chk("t2_p2", 32'(p2_score), 32'd3);
    chk("t2_rounds", 32'(round_cnt), 32'd4);
    chk("t2_inv", 32'(invalid_cnt), 32'd1);
    chk("t2_winner", 32'(match_winner), 32'd2);

    // Round limit with equal scores -> draw
    step(1'b1, 1'b0, 8'd0);
    play(8'd49); play(8'd50); play(8'd0); play(8'd0); play(8'd0);
    play(8'd0); play(8'd49); play(8'd50); play(8'd0);
    chk("t3_rounds", 32'(round_cnt), 32'd9);
    chk("t3_over", 32'(match_over), 32'd1);
    chk("t3_draw", 32'(match_winner), 32'd0);

    // Same sequence ending in 49 -> P1
    step(1'b1, 1'b0, 8'd0);
    play(8'd49); play(8'd50); play(8'd0); play(8'd0); play(8'd0);
    play(8'd0); play(8'd49); play(8'd50); play(8'd49);
    chk("t3b_winner", 32'(match_winner), 32'd1);

    // Unknown and invalid codes only touch invalid_cnt
    step(1'b1, 1'b0, 8'd0);
    play(8'hAA); play(8'd63);
    chk("t4_inv", 32'(invalid_cnt), 32'd2);
    chk("t4_rounds", 32'(round_cnt), 32'd0);
    chk("t4_play", 32'(res_if.result_ready), 32'd1);

    // Finish this match, then start and valid together in OVER
    play(8'd49); play(8'd49); play(8'd49);
    step(1'b1, 1'b1, 8'd49);
    chk("t5_p1", 32'(p1_score), 32'd0);
    chk("t5_ready", 32'(res_if.result_ready), 32'd1);

    // Reset mid-match, then start ignored while playing
    play(8'd49); play(8'd49);
    chk("t6_p1_pre", 32'(p1_score), 32'd2);
    step(1'b0, 1'b1, 8'd49, 1'b0);
    chk("t6_ready", 32'(res_if.result_ready), 32'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("t6_p1", 32'(p1_score), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [7:0] code;
      bit rn, st, v;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: code = 8'd49;
        3, 4, 5: code = 8'd50;
        6, 7:    code = 8'd0;
        8:       code = 8'd63;
        default: code = 8'($urandom);
      endcase
      rn = ($urandom_range(0, 299) != 0);
      st = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 3) != 0);
      step(st, v, code, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
